// File: rtl/multi_edge_detector_if.sv
// Signal bundle for multi_edge_detector: raw inputs and per-channel controls in, levels, pulses,
// pending flags and the combined interrupt out.
interface multi_edge_detector_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0]   i_det;
  logic [2*CHANNELS-1:0] i_mode;
  logic [CHANNELS-1:0]   i_clr;
  logic [CHANNELS-1:0]   o_level;
  logic [CHANNELS-1:0]   o_edge;
  logic [CHANNELS-1:0]   o_pend;
  logic                  o_irq;

  modport master (
    output i_det, i_mode, i_clr,
    input  o_level, o_edge, o_pend, o_irq
  );

  modport slave (
    input  i_det, i_mode, i_clr,
    output o_level, o_edge, o_pend, o_irq
  );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel synchronised edge detector with sticky W1C pending flags and an OR'd interrupt.
// Optional debounce filter is compiled in with MULTI_EDGE_DETECTOR_FILTER_EN.
module multi_edge_detector #(
  parameter int unsigned         CHANNELS      = 4,
  parameter int unsigned         SYNC_STAGES   = 2,
  parameter int unsigned         FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] INIT_LEVEL    = '0
) (
  input  logic                 i_chip_clk,
  input  logic                 i_rst_n,
  multi_edge_detector_if.slave bus
);

  if (CHANNELS < 1 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_CYCLES < 1) begin : g_param_err
    $error("multi_edge_detector: illegal parameter combination");
  end

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_s;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] edge_q, edge_d;
  logic [CHANNELS-1:0] pend_q, pend_d;

  always_ff @(posedge i_chip_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= INIT_LEVEL;
      end
    end else begin
      sync_q[0] <= bus.i_det;
      for (int unsigned st = 1; st < SYNC_STAGES; st++) begin
        sync_q[st] <= sync_q[st-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DETECTOR_FILTER_EN
  localparam int unsigned CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [CntW-1:0] cnt_q [CHANNELS];
  logic [CntW-1:0] cnt_d [CHANNELS];

  // A candidate level must persist FILTER_CYCLES consecutive cycles; any return restarts it.
  always_comb begin
    level_d = level_q;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      cnt_d[ch] = '0;
      if (sync_s[ch] != level_q[ch]) begin
        if (cnt_q[ch] == CntW'(FILTER_CYCLES - 1)) begin
          level_d[ch] = sync_s[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_chip_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end
`else
  always_comb begin
    level_d = sync_s;
  end
`endif

  always_comb begin
    edge_d = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      // Mode bit 0 enables rising edges, bit 1 enables falling edges.
      if (level_d[ch] != level_q[ch]) begin
        edge_d[ch] = level_d[ch] ? bus.i_mode[2*ch] : bus.i_mode[2*ch+1];
      end
    end
    pend_d = (pend_q & ~bus.i_clr) | edge_d;
  end

  always_ff @(posedge i_chip_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q <= INIT_LEVEL;
      edge_q  <= '0;
      pend_q  <= '0;
    end else begin
      level_q <= level_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.o_level = level_q;
  assign bus.o_edge  = edge_q;
  assign bus.o_pend  = pend_q;
  assign bus.o_irq   = |pend_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: hand sequences, a settle-state vector table and
// randomized stimulus checked every cycle against a sample-history reference model.
module tb_multi_edge_detector;

  localparam int SYNC = 2;
`ifdef MULTI_EDGE_DETECTOR_FILTER_EN
  localparam int  FE     = 4;
  localparam bit  FILT   = 1'b1;
`else
  localparam int  FE     = 1;
  localparam bit  FILT   = 1'b0;
`endif
  localparam int LAT = SYNC + FE;

  logic i_chip_clk;
  logic i_rst_n;

  multi_edge_detector_if #(.CHANNELS(4)) bus ();
  multi_edge_detector_if #(.CHANNELS(4)) bus1 ();

  multi_edge_detector #(
    .CHANNELS(4), .SYNC_STAGES(SYNC), .FILTER_CYCLES(4), .INIT_LEVEL(4'b0000)
  ) dut (
    .i_chip_clk(i_chip_clk), .i_rst_n(i_rst_n), .bus(bus.slave)
  );

  multi_edge_detector #(
    .CHANNELS(4), .SYNC_STAGES(SYNC), .FILTER_CYCLES(4), .INIT_LEVEL(4'b0101)
  ) dut_init (
    .i_chip_clk(i_chip_clk), .i_rst_n(i_rst_n), .bus(bus1.slave)
  );

  initial begin
    i_chip_clk = 1'b0;
    forever #5 i_chip_clk = ~i_chip_clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples delayed SYNC cycles, accepted once FE consecutive samples
  // all disagree with the current level.
  logic [3:0] m_q[$];
  logic [3:0] m_win[$];
  logic [3:0] m_lvl, m_pend, m_edge;

  task automatic model_reset();
    m_q.delete();
    m_win.delete();
    for (int k = 0; k < SYNC; k++) m_q.push_back(4'b0000);
    m_lvl  = 4'b0000;
    m_pend = 4'b0000;
    m_edge = 4'b0000;
  endtask

  task automatic model_step();
    logic [3:0] s_pre, nlvl, nedge;
    logic [1:0] mp;
    bit acc;
    m_q.push_back(bus.i_det);
    s_pre = m_q[m_q.size() - 1 - SYNC];
    if (m_q.size() > SYNC + 1) m_q.delete(0);
    m_win.push_back(s_pre);
    if (m_win.size() > FE) m_win.delete(0);
    nlvl  = m_lvl;
    nedge = 4'b0000;
    for (int ch = 0; ch < 4; ch++) begin
      acc = (m_win.size() == FE);
      foreach (m_win[w]) if (m_win[w][ch] == m_lvl[ch]) acc = 0;
      if (acc) begin
        nlvl[ch]  = ~m_lvl[ch];
        mp        = bus.i_mode[2*ch +: 2];
        nedge[ch] = nlvl[ch] ? mp[0] : mp[1];
      end
    end
    m_pend = (m_pend & ~bus.i_clr) | nedge;
    m_edge = nedge;
    m_lvl  = nlvl;
  endtask

  task automatic step();
    @(posedge i_chip_clk);
    model_step();
    #1;
    chk("step_level", 32'(bus.o_level), 32'(m_lvl));
    chk("step_edge",  32'(bus.o_edge),  32'(m_edge));
    chk("step_pend",  32'(bus.o_pend),  32'(m_pend));
    chk("step_irq",   32'(bus.o_irq),   32'(|m_pend));
  endtask

  task automatic async_reset();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(bus.o_level), 32'h0);
    chk("arst_edge",  32'(bus.o_edge),  32'h0);
    chk("arst_pend",  32'(bus.o_pend),  32'h0);
    chk("arst_irq",   32'(bus.o_irq),   32'h0);
    model_reset();
    @(negedge i_chip_clk);
    i_rst_n = 1'b1;
  endtask

  logic init_seen_edge = 1'b0;
  always @(negedge i_chip_clk) begin
    if (i_rst_n && (bus1.o_edge != 4'b0000 || bus1.o_pend != 4'b0000)) init_seen_edge <= 1'b1;
  end

  typedef struct {
    logic [3:0] det;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] exp_level;
    logic [3:0] exp_pend;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int seen, lvl_seen, pulses;

    vecs[0] = '{4'b1111, 8'b01010101, 4'b0000, 4'b1111, 4'b1111};
    vecs[1] = '{4'b0000, 8'b10101010, 4'b1111, 4'b0000, 4'b0000};
    vecs[2] = '{4'b0011, 8'b00000000, 4'b0000, 4'b0011, 4'b0000};
    vecs[3] = '{4'b1100, 8'b11111111, 4'b0000, 4'b1100, 4'b1111};
    vecs[4] = '{4'b1100, 8'b11111111, 4'b0101, 4'b1100, 4'b1010};
    vecs[5] = '{4'b0110, 8'b01010101, 4'b0000, 4'b0110, 4'b1010};
    vecs[6] = '{4'b1001, 8'b10101010, 4'b1000, 4'b1001, 4'b0110};
    vecs[7] = '{4'b1001, 8'b00000000, 4'b1111, 4'b1001, 4'b0000};

    bus.i_det   = 4'b0000;
    bus.i_mode  = 8'h00;
    bus.i_clr   = 4'b0000;
    bus1.i_det  = 4'b0101;
    bus1.i_mode = 8'hFF;
    bus1.i_clr  = 4'b0000;
    i_rst_n     = 1'b0;
    model_reset();
    repeat (3) @(negedge i_chip_clk);
    chk("rst_level", 32'(bus.o_level), 32'h0);
    chk("rst_pend",  32'(bus.o_pend),  32'h0);
    chk("rst_irq",   32'(bus.o_irq),   32'h0);
    chk("rst_init_level", 32'(bus1.o_level), 32'h5);
    i_rst_n = 1'b1;
    repeat (4) step();

    // Latency: rise on ch0 with rise mode pulses exactly at edge LAT.
    bus.i_mode = 8'b00_11_01_01;
    bus.i_det[0] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      chk("lat_edge0", 32'(bus.o_edge[0]), 32'(k == LAT));
    end
    chk("lat_pend0", 32'(bus.o_pend[0]), 32'h1);
    chk("lat_irq",   32'(bus.o_irq),     32'h1);
    bus.i_det[0] = 1'b0;
    seen = 0;
    repeat (LAT + 2) begin
      step();
      seen |= int'(bus.o_edge[0]);
    end
    chk("fall_no_pulse0", 32'(seen), 32'h0);
    chk("fall_level0", 32'(bus.o_level[0]), 32'h0);

    // Glitch rejection on ch1.
    bus.i_det[1] = 1'b1;
    seen = 0; lvl_seen = 0;
    repeat (3) begin step(); seen |= int'(bus.o_edge[1]); lvl_seen |= int'(bus.o_level[1]); end
    bus.i_det[1] = 1'b0;
    repeat (LAT + 4) begin step(); seen |= int'(bus.o_edge[1]); lvl_seen |= int'(bus.o_level[1]); end
    chk("glitch3_pulse", 32'(seen), 32'(!FILT));
    chk("glitch3_level", 32'(lvl_seen), 32'(!FILT));
    bus.i_det[1] = 1'b1;
    seen = 0;
    repeat (4) begin step(); seen |= int'(bus.o_edge[1]); end
    bus.i_det[1] = 1'b0;
    repeat (LAT + 4) begin step(); seen |= int'(bus.o_edge[1]); end
    chk("glitch4_pulse", 32'(seen), 32'h1);

    // Both edges on ch2, clear coinciding with the second pulse.
    pulses = 0;
    bus.i_det[2] = 1'b1;
    repeat (LAT + 2) begin step(); pulses += int'(bus.o_edge[2]); end
    bus.i_det[2] = 1'b0;
    repeat (LAT - 1) begin step(); pulses += int'(bus.o_edge[2]); end
    bus.i_clr = 4'b0100;
    step();
    pulses += int'(bus.o_edge[2]);
    chk("both_pulses", 32'(pulses), 32'h2);
    chk("clr_same_cycle_pend2", 32'(bus.o_pend[2]), 32'h1);
    bus.i_clr = 4'b1111;
    step();
    chk("clr_next_pend", 32'(bus.o_pend), 32'h0);
    chk("clr_next_irq",  32'(bus.o_irq),  32'h0);
    bus.i_clr = 4'b0000;

    // Mode off on ch3: level tracks, nothing pulses; enabling the mode later adds nothing.
    seen = 0;
    for (int t = 0; t < 4; t++) begin
      bus.i_det[3] = ~bus.i_det[3];
      repeat (LAT + 1) begin step(); seen |= int'(bus.o_edge[3] | bus.o_pend[3]); end
      chk("off_level3", 32'(bus.o_level[3]), 32'(bus.i_det[3]));
    end
    bus.i_mode[7:6] = 2'b11;
    repeat (LAT + 2) begin step(); seen |= int'(bus.o_edge[3] | bus.o_pend[3]); end
    chk("off_no_pulse3", 32'(seen), 32'h0);

    // Reset in the middle of filtering; input stays high so it is detected afresh.
    bus.i_det = 4'b1111;
    repeat (2) step();
    async_reset();
    repeat (2 * LAT + 2) step();
    chk("post_rst_pend", 32'(bus.o_pend), 32'hF);

    // Settle-state vector table.
    bus.i_det = 4'b0000; bus.i_mode = 8'h00; bus.i_clr = 4'b1111;
    repeat (2 * LAT + 2) step();
    foreach (vecs[v]) begin
      bus.i_det  = vecs[v].det;
      bus.i_mode = vecs[v].mode;
      bus.i_clr  = vecs[v].clr;
      repeat (12) step();
      chk($sformatf("vec%0d_level", v), 32'(bus.o_level), 32'(vecs[v].exp_level));
      chk($sformatf("vec%0d_pend", v),  32'(bus.o_pend),  32'(vecs[v].exp_pend));
      chk($sformatf("vec%0d_irq", v),   32'(bus.o_irq),   32'(vecs[v].exp_pend != 4'b0000));
    end
    bus.i_clr = 4'b0000;

    // Randomized traffic against the model.
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(3) == 0) bus.i_det = bus.i_det ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(15) == 0) bus.i_mode = 8'($urandom);
      bus.i_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if (it == 250) async_reset();
      step();
    end

    chk("init_level_held", 32'(bus1.o_level), 32'h5);
    chk("init_no_edge",    32'(init_seen_edge), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Multi-channel, parametrised edge detector for the SPI master and its surrounding control logic. Each of `CHANNELS` asynchronous inputs is synchronised, optionally debounced, and edge-classified per channel as rise, fall, both or off. Each detected edge produces a one-cycle pulse and a sticky pending flag with write-one-to-clear. A combined interrupt line is driven from the pending flags.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent input channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (2..4).
- `FILTER_CYCLES`, 4: consecutive cycles a new level must persist before it is accepted (≥1). Only used with the filter compiled in.
- `INIT_LEVEL`, `{CHANNELS{1'b0}}`: reset value of the synchroniser chain and the accepted level, per channel.

Ports:
- `i_chip_clk` in 1: the single clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_det` in `CHANNELS`: raw inputs, asynchronous to `i_chip_clk`.
- `i_mode` in `2*CHANNELS`: per-channel mode, bits `[2i+1:2i]`.
  - 00: off.
  - 01: rising edges.
  - 10: falling edges.
  - 11: both edges.
- `i_clr` in `CHANNELS`: write-one-to-clear for the pending flags; level-sampled every cycle.
- `o_level` out `CHANNELS`: accepted (synchronised, filtered) level.
- `o_edge` out `CHANNELS`: one-cycle pulse per accepted edge that matches the channel's mode.
- `o_pend` out `CHANNELS`: sticky pending flags.
- `o_irq` out 1: OR of `o_pend`.

## Operation
- **Synchroniser.** Each channel has a `SYNC_STAGES`-deep flop chain. Its last stage is `s[i]`.
- **Filter.** Each channel has a counter `cnt[i]` of width `$clog2(FILTER_CYCLES)` (minimum 1).
  - If `s[i] == o_level[i]`: `cnt <= 0`.
  - Else if `cnt == FILTER_CYCLES-1`: `o_level[i] <= s[i]` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any return of `s[i]` to `o_level[i]` before acceptance discards the candidate, so glitches shorter than `FILTER_CYCLES` are rejected.
- **Edge detection.** `o_edge[i]` is registered and is asserted on the same edge where `o_level[i]` changes.
  - It requires a rise (0→1) with mode bit 0 set, or a fall (1→0) with mode bit 1 set.
  - Mode 00 still updates `o_level` but never pulses or sets a pending flag.
- **Pending flags.** `o_pend[i] <= (o_pend[i] & ~i_clr[i]) | edge_next[i]`.
  - A set and a clear in the same cycle: set wins.
  - Clearing a flag that is already 0 has no effect.
- **Mode changes.** A change of `i_mode` takes effect on the next level change. The mode change itself never generates an edge, and existing pending flags are not altered.
- **Channel independence.** Channels are fully independent. Any combination of channels may pulse in the same cycle.
- **Interrupt.** `o_irq` is combinational: `|o_pend`, with no extra latency.

## Timing
- **Reset (async assert, sync deassert assumed externally):**
  - Synchroniser and `o_level` load `INIT_LEVEL`.
  - `cnt`, `o_edge` and `o_pend` reset to 0; `o_irq` resets to 0.
  - No edge is generated after reset when `i_det` equals `INIT_LEVEL`. A differing `i_det` is detected as a normal edge after the latency below.
- **Latency.** Let edge 1 be the first rising edge of `i_chip_clk` that samples a new `i_det` value.
  - `s[i]` changes at edge `SYNC_STAGES`.
  - `o_level`/`o_edge` change at edge `SYNC_STAGES+FILTER_CYCLES`.
  - `o_pend` is set on that same edge.
- **Pulse width.** `o_edge` is high for exactly one cycle.
- **Minimum input spacing.** Accepted edges are at least `FILTER_CYCLES` cycles apart.
- **Reset mid-filter.** A reset during filtering aborts the candidate, and no edge is produced for it.

## Configuration
- **`MULTI_EDGE_DETECTOR_FILTER_EN` defined:** the debounce filter and counters are present, as described above.
- **Not defined:**
  - No counters are instantiated and `FILTER_CYCLES` is ignored.
  - `o_level[i] <= s[i]` every cycle.
  - Latency becomes `SYNC_STAGES+1` edges; all other behaviour is identical.

## Test plan
- **Reset behaviour.** `INIT_LEVEL=4'b0101`, `i_det=4'b0101` held through and after reset → `o_edge=0`, `o_pend=0`, `o_level=4'b0101` indefinitely.
- **Latency check.** Defaults, mode 01 on ch0, `i_det[0]` 0→1 → `o_edge[0]` pulses exactly one cycle at edge 6, `o_pend[0]=1`, `o_irq=1`. Fall on ch0 → no pulse.
- **Glitch rejection.** `i_det[1]` high for 3 cycles then low (filter on, `FILTER_CYCLES=4`) → no pulse, `o_level[1]` stays 0. High for 4 cycles → pulse.
- **Both-edges and clear.** Mode 11 on ch2, rise then fall → two pulses, `o_pend[2]` set. `i_clr[2]` asserted in the same cycle as the second pulse → `o_pend[2]` remains 1. Clear one cycle later → 0, `o_irq=0`.
- **Mode off.** Mode 00 on ch3 with toggling input → `o_level[3]` tracks the input, with no `o_edge[3]` or `o_pend[3]`. Switching mode to 11 while the level is stable → no pulse.
- **Filter compiled out and async reset.** With `MULTI_EDGE_DETECTOR_FILTER_EN` undefined → a rise pulses at edge 3 and a 1-cycle glitch is passed through. Asserting `i_rst_n` low mid-count → all outputs clear immediately.
